// File: rtl/program_loader_if.sv
// Nibble stream into the loader and instruction-memory write bus out of it.
// The loader connects through the slave modport, the feeding side through master.
interface program_loader_if;
  logic [3:0]  nibble_in;
  logic        nibble_valid;
  logic        nibble_ready;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_wren;

  modport master (
    output nibble_in, nibble_valid,
    input  nibble_ready, mem_address, mem_data, mem_wren
  );

  modport slave (
    input  nibble_in, nibble_valid,
    output nibble_ready, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/program_loader.sv
// Assembles MSB-first nibbles into 16-bit words and writes them to instruction
// memory from address 0, stopping on a HALT word or when DEPTH words are written.
//
// state   | meaning
// IDLE    | waiting for start after reset
// COLLECT | accepting nibbles of the current word
// WRITE   | one-cycle memory write of the assembled word
// DONE    | session over; results held until the next start
module program_loader #(
  parameter int DEPTH       = 256,
  parameter int HALT_DETECT = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  program_loader_if.slave    bus,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [15:0]        word_count
);

  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  nib_idx;
  logic [11:0] partial;
  logic [15:0] address;
  logic [15:0] data;
  logic        is_halt;
  logic        at_last;
  logic        take_nib;

  assign is_halt  = (HALT_DETECT != 0) && (data[15:14] == 2'b11) && (data[7:4] == 4'hF);
  assign at_last  = (address == LAST_ADDR);
  assign take_nib = (state == COLLECT) && bus.nibble_valid;

  assign bus.mem_address = address;
  assign bus.mem_data    = data;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    bus.nibble_ready = 1'b0;
    bus.mem_wren     = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = COLLECT;
      end
      COLLECT: begin
        bus.nibble_ready = 1'b1;
        busy             = 1'b1;
        if (take_nib && nib_idx == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        bus.mem_wren = 1'b1;
        busy         = 1'b1;
        if (is_halt || at_last) state_next = DONE;
        else                    state_next = COLLECT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  // The address saturates at the last word; the count still records every write.
  always_ff @(posedge clock) begin
    if (reset) begin
      nib_idx    <= 2'd0;
      partial    <= 12'h000;
      address    <= 16'h0000;
      data       <= 16'h0000;
      word_count <= 16'h0000;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nib_idx    <= 2'd0;
            partial    <= 12'h000;
            address    <= 16'h0000;
            word_count <= 16'h0000;
            overflow   <= 1'b0;
          end
        end
        COLLECT: begin
          if (take_nib) begin
            nib_idx <= nib_idx + 2'd1;
            if (nib_idx == 2'd3) data    <= {partial, bus.nibble_in};
            else                 partial <= {partial[7:0], bus.nibble_in};
          end
        end
        WRITE: begin
          word_count <= word_count + 16'd1;
          if (!at_last) address <= address + 16'd1;
          overflow <= at_last && !is_halt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench: dut_a runs default parameters, dut_b runs DEPTH=4 without HALT
// detection; both see the same nibble stream and their writes are logged.
module tb_program_loader;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       nvalid = 1'b0;
  logic [3:0] nib = 4'h0;

  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [15:0] cnt_a, cnt_b;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [15:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int          wa_cyc[$], acc_cyc[$];

  program_loader_if ia ();
  program_loader_if ib ();

  assign ia.nibble_in    = nib;
  assign ia.nibble_valid = nvalid;
  assign ib.nibble_in    = nib;
  assign ib.nibble_valid = nvalid;

  program_loader #(.DEPTH(256), .HALT_DETECT(1)) dut_a (
    .clock(clock), .reset(reset), .start(start), .bus(ia.slave),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .word_count(cnt_a)
  );

  program_loader #(.DEPTH(4), .HALT_DETECT(0)) dut_b (
    .clock(clock), .reset(reset), .start(start), .bus(ib.slave),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .word_count(cnt_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ia.mem_wren) begin
      wa_addr.push_back(ia.mem_address);
      wa_data.push_back(ia.mem_data);
      wa_cyc.push_back(cyc);
    end
    if (ia.nibble_valid && ia.nibble_ready) acc_cyc.push_back(cyc);
    if (ib.mem_wren) begin
      wb_addr.push_back(ib.mem_address);
      wb_data.push_back(ib.mem_data);
    end
    cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_logs();
    wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
    wb_addr.delete(); wb_data.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n, input bit use_b);
    logic rdy;
    bit   ok;
    ok     = 1'b0;
    nib    = n;
    nvalid = 1'b1;
    for (int i = 0; i < 16 && !ok; i++) begin
      rdy = use_b ? ib.nibble_ready : ia.nibble_ready;
      @(negedge clock);
      if (rdy) ok = 1'b1;
    end
    nvalid = 1'b0;
    if (!ok) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input bit use_b);
    for (int i = 3; i >= 0; i--) send_nib(w[i*4 +: 4], use_b);
  endtask

  task automatic check_a_idle(input string tag);
    check_val({tag, "_flags"},
              {27'd0, ia.nibble_ready, ia.mem_wren, busy_a, done_a, ovf_a}, 32'd0);
    check_val({tag, "_addr"}, ia.mem_address, 32'h0);
    check_val({tag, "_data"}, ia.mem_data, 32'h0);
    check_val({tag, "_cnt"}, cnt_a, 32'h0);
  endtask

  initial begin
    logic [3:0] seq [8];
    int         k;
    logic       rdy;
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

    // reset dominates start and nibble_valid
    start = 1'b1; nvalid = 1'b1;
    tick(3);
    check_a_idle("rst");
    start = 1'b0; nvalid = 1'b0; reset = 1'b0;
    tick(1);
    check_val("rst_busy", busy_a, 32'd0);

    // two words, second one HALT
    do_reset();
    pulse_start();
    check_val("t1_ready", ia.nibble_ready, 32'd1);
    send_word(16'h8105, 1'b0);
    check_val("t1_wren", ia.mem_wren, 32'd1);
    check_val("t1_wdata0", ia.mem_data, 32'h8105);
    check_val("t1_waddr0", ia.mem_address, 32'h0);
    send_word(16'hC0F0, 1'b0);
    tick(1);
    check_val("t1_done", {done_a, ovf_a, busy_a}, 32'b100);
    check_val("t1_cnt", cnt_a, 32'd2);
    check_val("t1_addr", ia.mem_address, 32'd2);
    check_val("t1_data", ia.mem_data, 32'hC0F0);
    check_val("t1_nw", wa_data.size(), 32'd2);
    check_val("t1_w1", {wa_addr[1], wa_data[1]}, {16'd1, 16'hC0F0});
    check_val("t1_b_cnt", {busy_b, cnt_b}, {1'b1, 16'd2});

    // HALT word ignored on dut_b, DEPTH=4 overflow
    do_reset();
    pulse_start();
    send_word(16'hC0F0, 1'b1);
    tick(1);
    check_val("t2_a_halt", {done_a, ovf_a, cnt_a, ia.mem_address}, {2'b10, 16'd1, 16'd1});
    check_val("t2_b_cont", {busy_b, done_b, cnt_b}, {2'b10, 16'd1});
    send_word(16'h1234, 1'b1);
    tick(1);
    check_val("t2_b_cnt2", cnt_b, 32'd2);
    send_word(16'h5678, 1'b1);
    send_word(16'h9ABC, 1'b1);
    tick(1);
    check_val("t2_b_ovf", {done_b, ovf_b, busy_b}, 32'b110);
    check_val("t2_b_cnt4", cnt_b, 32'd4);
    check_val("t2_b_addr", ib.mem_address, 32'd3);
    check_val("t2_b_nw", wb_data.size(), 32'd4);
    check_val("t2_b_w0", {wb_addr[0], wb_data[0]}, {16'd0, 16'hC0F0});
    check_val("t2_b_w3", {wb_addr[3], wb_data[3]}, {16'd3, 16'h9ABC});
    nvalid = 1'b1;
    tick(5);
    nvalid = 1'b0;
    check_val("t2_b_ign", {wb_data.size(), cnt_b, ib.nibble_ready}, {32'd4, 16'd4, 1'b0});

    // nibble_valid held high continuously
    do_reset();
    pulse_start();
    k = 0;
    nvalid = 1'b1;
    for (int i = 0; i < 40 && k < 8; i++) begin
      nib = seq[k];
      rdy = ia.nibble_ready;
      @(negedge clock);
      if (rdy) k++;
    end
    nvalid = 1'b0;
    tick(2);
    check_val("t3_nacc", acc_cyc.size(), 32'd8);
    check_val("t3_lat0", wa_cyc[0], 32'(acc_cyc[3] + 1));
    check_val("t3_lat1", wa_cyc[1], 32'(acc_cyc[7] + 1));
    check_val("t3_gap", acc_cyc[4], 32'(acc_cyc[3] + 2));
    check_val("t3_words", {wa_data[0], wa_data[1]}, {16'h1234, 16'h5678});

    // reset after two nibbles of the second word
    do_reset();
    pulse_start();
    send_word(16'h1234, 1'b0);
    send_nib(4'h1, 1'b0);
    send_nib(4'h2, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_a_idle("t4_rst");
    clear_logs();
    pulse_start();
    send_word(16'h3456, 1'b0);
    tick(1);
    check_val("t4_w0", {wa_addr[0], wa_data[0]}, {16'd0, 16'h3456});

    // reset during WRITE: that write is the last one
    do_reset();
    pulse_start();
    send_word(16'h7777, 1'b0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    check_val("t5_nw", wa_data.size(), 32'd1);
    check_val("t5_state", {busy_a, cnt_a, ia.mem_address}, 33'd0);

    // start with nibble in IDLE, start ignored mid-session
    do_reset();
    start = 1'b1; nvalid = 1'b1; nib = 4'h9;
    tick(1);
    start = 1'b0; nvalid = 1'b0;
    send_word(16'hABCD, 1'b0);
    tick(1);
    check_val("t6_cnt1", cnt_a, 32'd1);
    pulse_start();
    check_val("t6_ign", {busy_a, cnt_a, ia.mem_address}, {1'b1, 16'd1, 16'd1});
    send_word(16'h1111, 1'b0);
    tick(1);
    check_val("t6_cnt2", cnt_a, 32'd2);
    check_val("t6_w0", {wa_addr[0], wa_data[0]}, {16'd0, 16'hABCD});
    check_val("t6_w1", {wa_addr[1], wa_data[1]}, {16'd1, 16'h1111});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
